ras_predictor: RTL and testbench
================================

Name: ras_predictor

Overview:
Return-address-stack stage directly downstream of the BTB in the BPU. It consumes the BTB's registered prediction (able, next PC, type, hit bank) together with the fetch block's return address. On a predicted return it overrides the target with the stack top; on a predicted call it pushes the return address. The corrected prediction and a stack checkpoint are presented to the PC-select and TAGE stage one cycle later. The backend can restore the stack from a checkpoint on a mispredict flush.

Parameters:
DEPTH, 16, number of stack entries (power of two)
PTR_W, 4, log2(DEPTH)
TYPE_CALL, 3'd2, BTB type code for a call
TYPE_RET, 3'd3, BTB type code for a return

Ports:
Clk  in  1  clock, rising edge
Rest  in  1  reset, asynchronous, active-low
BtbAble  in  1  BTB prediction valid this cycle
BtbPc  in  32  BTB predicted next PC
BtbType  in  3  BTB predicted branch type
BtbHitBank  in  2  BTB hit bank (01/10/00)
CallRetAddr  in  32  return address of the call in this fetch block
FlushAble  in  1  backend mispredict restore
FlushPtr  in  PTR_W  checkpointed top pointer
FlushCnt  in  PTR_W+1  checkpointed occupancy
FlushTopData  in  32  checkpointed top-of-stack value
RasAble  out  1  prediction valid
RasNextPc  out  32  final predicted next PC
RasNextType  out  3  type passed through
RasHitBank  out  2  hit bank passed through
RasUsed  out  1  1 = RasNextPc came from the stack
RasPtr  out  PTR_W  top pointer before this prediction's update (checkpoint)
RasCnt  out  PTR_W+1  occupancy before this prediction's update (checkpoint)

Behaviour:
- Storage: DEPTH x 32 circular array, pointer Ptr (next free slot), occupancy Cnt in 0..DEPTH. The top entry is stack[Ptr-1] modulo DEPTH.
- Reset (Rest=0, async): Ptr=0, Cnt=0, all entries 0, all outputs 0.
- Latency: 1 cycle. Outputs are registered. When BtbAble=0 (and no flush), the next cycle has RasAble=0 and RasNextPc/Type/HitBank/RasUsed/RasPtr/RasCnt=0.
- When BtbAble=1 (no flush):
  - The output regs capture RasPtr=Ptr and RasCnt=Cnt (pre-update values), plus RasHitBank=BtbHitBank and RasNextType=BtbType.
  - BtbType==TYPE_RET and Cnt>0: RasNextPc=stack[Ptr-1], RasUsed=1, Ptr-=1 (mod DEPTH), Cnt-=1.
  - BtbType==TYPE_RET and Cnt==0 (empty): RasNextPc=BtbPc, RasUsed=0, state unchanged.
  - BtbType==TYPE_CALL: stack[Ptr]=CallRetAddr, Ptr+=1 (mod DEPTH), Cnt=min(Cnt+1,DEPTH), RasNextPc=BtbPc, RasUsed=0.
  - Full (Cnt==DEPTH) push: overwrites the oldest entry, Cnt stays DEPTH. Pointer wrap from DEPTH-1 to 0 is silent.
  - Any other type: pass-through, RasNextPc=BtbPc, RasUsed=0, no state change.
- Flush (FlushAble=1) has priority over BtbAble in the same cycle:
  - Ptr=FlushPtr, Cnt=FlushCnt.
  - If FlushCnt!=0, stack[FlushPtr-1]=FlushTopData.
  - The BTB input that cycle is dropped; next-cycle RasAble=0.
- A push and a read of the same slot never occur in one cycle: a single operation is performed per cycle.
- Reset asserted mid-sequence clears the stack immediately and asynchronously. No pending prediction survives.

Test Plan:
- Reset, then BtbAble=1, Type=CALL, CallRetAddr=0x1C000104, BtbPc=0x1C000800 -> next cycle RasAble=1, RasNextPc=0x1C000800, RasUsed=0, RasPtr=0, RasCnt=0. Internal Ptr=1, Cnt=1.
- Follow with Type=RET, BtbPc=0x0 -> RasNextPc=0x1C000104, RasUsed=1, RasPtr=1, RasCnt=1. Stack returns to empty.
- RET on empty stack with BtbPc=0x1C000040 -> RasNextPc=0x1C000040, RasUsed=0, RasCnt=0.
- 17 CALLs with addresses 0x100+4k (k=0..16), then 17 RETs -> the first 16 RETs return 0x140 down to 0x104 with RasUsed=1. The 17th RET has RasUsed=0 and returns BtbPc.
- Same-cycle FlushAble=1 (FlushPtr=3, FlushCnt=3, FlushTopData=0xABCD0000) and BtbAble=1 CALL -> next cycle RasAble=0. A following RET returns 0xABCD0000 with RasPtr=3.
- Assert Rest low between two valid predictions -> outputs go to 0 immediately. After release, a RET gives RasUsed=0.

Source files
------------

// File: rtl/ras_predictor.sv
// -----------------------------------------------------------------------------
// ras_predictor
//
// Return-address-stack stage that sits directly behind the BTB in the branch
// prediction unit. It takes the BTB's registered prediction and the fetch
// block's call return address, and corrects the predicted next PC:
//   - a predicted return takes its target from the top of the stack,
//   - a predicted call pushes its return address,
//   - every other type passes straight through.
// The corrected prediction, plus a checkpoint of the stack pointer and
// occupancy taken before this prediction's update, is registered and
// presented one cycle later. The backend restores the stack from such a
// checkpoint when it flushes on a mispredict.
//
// Ports
//   Clk           in   clock, rising edge
//   Rest          in   asynchronous active-low reset
//   BtbAble       in   BTB prediction valid this cycle
//   BtbPc         in   BTB predicted next PC
//   BtbType       in   BTB predicted branch type
//   BtbHitBank    in   BTB hit bank
//   CallRetAddr   in   return address of the call in this fetch block
//   FlushAble     in   backend mispredict restore (wins over BtbAble)
//   FlushPtr      in   checkpointed top pointer
//   FlushCnt      in   checkpointed occupancy
//   FlushTopData  in   checkpointed top-of-stack value
//   RasAble       out  prediction valid
//   RasNextPc     out  final predicted next PC
//   RasNextType   out  branch type passed through
//   RasHitBank    out  hit bank passed through
//   RasUsed       out  1 when RasNextPc came from the stack
//   RasPtr        out  top pointer before this prediction's update
//   RasCnt        out  occupancy before this prediction's update
// -----------------------------------------------------------------------------
module ras_predictor #(
    parameter int         DEPTH     = 16,
    parameter int         PTR_W     = 4,
    parameter logic [2:0] TYPE_CALL = 3'd2,
    parameter logic [2:0] TYPE_RET  = 3'd3
) (
    input  logic               Clk,
    input  logic               Rest,
    input  logic               BtbAble,
    input  logic [31:0]        BtbPc,
    input  logic [2:0]         BtbType,
    input  logic [1:0]         BtbHitBank,
    input  logic [31:0]        CallRetAddr,
    input  logic               FlushAble,
    input  logic [PTR_W-1:0]   FlushPtr,
    input  logic [PTR_W:0]     FlushCnt,
    input  logic [31:0]        FlushTopData,
    output logic               RasAble,
    output logic [31:0]        RasNextPc,
    output logic [2:0]         RasNextType,
    output logic [1:0]         RasHitBank,
    output logic               RasUsed,
    output logic [PTR_W-1:0]   RasPtr,
    output logic [PTR_W:0]     RasCnt
);

    // Occupancy value meaning "every slot holds a live entry".
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------------
    // Stack state
    // ---------------------------------------------------------------------
    logic [31:0]      stack_q [DEPTH];
    logic [31:0]      stack_d [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W:0]   cnt_q;
    logic [PTR_W:0]   cnt_d;

    // ---------------------------------------------------------------------
    // Registered prediction outputs
    // ---------------------------------------------------------------------
    logic             ras_able_q;
    logic             ras_able_d;
    logic [31:0]      ras_next_pc_q;
    logic [31:0]      ras_next_pc_d;
    logic [2:0]       ras_next_type_q;
    logic [2:0]       ras_next_type_d;
    logic [1:0]       ras_hit_bank_q;
    logic [1:0]       ras_hit_bank_d;
    logic             ras_used_q;
    logic             ras_used_d;
    logic [PTR_W-1:0] ras_ptr_q;
    logic [PTR_W-1:0] ras_ptr_d;
    logic [PTR_W:0]   ras_cnt_q;
    logic [PTR_W:0]   ras_cnt_d;

    // ---------------------------------------------------------------------
    // Single write port into the stack; at most one operation per cycle,
    // so a push and a top-of-stack read never target the same slot at once.
    // ---------------------------------------------------------------------
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [31:0]      wr_data;

    // Slot holding the current top of stack (wraps silently below zero).
    logic [PTR_W-1:0] top_idx;
    logic [31:0]      top_data;

    // A checkpoint occupancy above DEPTH cannot be legal; saturating it keeps
    // the stack from believing it holds more entries than it has slots.
    logic [PTR_W:0]   flush_cnt_sat;

    // Top-of-stack lookup and checkpoint occupancy sanitising.
    always_comb begin
        top_idx  = ptr_q - PTR_ONE;
        top_data = stack_q[top_idx];
        if (FlushCnt > CNT_FULL) begin
            flush_cnt_sat = CNT_FULL;
        end else begin
            flush_cnt_sat = FlushCnt;
        end
    end

    // Next-state and next-output decode: flush first, then prediction.
    always_comb begin
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        wr_en           = 1'b0;
        wr_idx          = ptr_q;
        wr_data         = CallRetAddr;
        ras_able_d      = 1'b0;
        ras_next_pc_d   = 32'h0000_0000;
        ras_next_type_d = 3'd0;
        ras_hit_bank_d  = 2'd0;
        ras_used_d      = 1'b0;
        ras_ptr_d       = {PTR_W{1'b0}};
        ras_cnt_d       = {(PTR_W+1){1'b0}};

        if (FlushAble) begin
            // Restore from checkpoint; the BTB input this cycle is dropped.
            ptr_d = FlushPtr;
            cnt_d = flush_cnt_sat;
            if (flush_cnt_sat != {(PTR_W+1){1'b0}}) begin
                // The top slot may have been clobbered by wrong-path pushes,
                // so the checkpoint carries its value back in.
                wr_en   = 1'b1;
                wr_idx  = FlushPtr - PTR_ONE;
                wr_data = FlushTopData;
            end else begin
                wr_en = 1'b0;
            end
        end else if (BtbAble) begin
            ras_able_d      = 1'b1;
            ras_next_type_d = BtbType;
            ras_hit_bank_d  = BtbHitBank;
            ras_ptr_d       = ptr_q;
            ras_cnt_d       = cnt_q;
            ras_next_pc_d   = BtbPc;
            case (BtbType)
                TYPE_RET: begin
                    if (cnt_q != {(PTR_W+1){1'b0}}) begin
                        ras_next_pc_d = top_data;
                        ras_used_d    = 1'b1;
                        ptr_d         = ptr_q - PTR_ONE;
                        cnt_d         = cnt_q - CNT_ONE;
                    end else begin
                        // Empty stack: fall back to the BTB target.
                        ras_used_d = 1'b0;
                    end
                end
                TYPE_CALL: begin
                    // When full, this overwrites the oldest entry, which is
                    // exactly the slot the pointer has wrapped around to.
                    wr_en   = 1'b1;
                    wr_idx  = ptr_q;
                    wr_data = CallRetAddr;
                    ptr_d   = ptr_q + PTR_ONE;
                    if (cnt_q < CNT_FULL) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = CNT_FULL;
                    end
                end
                default: begin
                    ras_used_d = 1'b0;
                end
            endcase
        end else begin
            ras_able_d = 1'b0;
        end
    end

    // Next contents of the stack array from the single write port.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = stack_q[i];
        end
        if (wr_en) begin
            stack_d[wr_idx] = wr_data;
        end else begin
            stack_d[wr_idx] = stack_q[wr_idx];
        end
    end

    // Stack storage, pointer and occupancy registers.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= 32'h0000_0000;
            end
            ptr_q <= {PTR_W{1'b0}};
            cnt_q <= {(PTR_W+1){1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Registered prediction and checkpoint outputs.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            ras_able_q      <= 1'b0;
            ras_next_pc_q   <= 32'h0000_0000;
            ras_next_type_q <= 3'd0;
            ras_hit_bank_q  <= 2'd0;
            ras_used_q      <= 1'b0;
            ras_ptr_q       <= {PTR_W{1'b0}};
            ras_cnt_q       <= {(PTR_W+1){1'b0}};
        end else begin
            ras_able_q      <= ras_able_d;
            ras_next_pc_q   <= ras_next_pc_d;
            ras_next_type_q <= ras_next_type_d;
            ras_hit_bank_q  <= ras_hit_bank_d;
            ras_used_q      <= ras_used_d;
            ras_ptr_q       <= ras_ptr_d;
            ras_cnt_q       <= ras_cnt_d;
        end
    end

    assign RasAble     = ras_able_q;
    assign RasNextPc   = ras_next_pc_q;
    assign RasNextType = ras_next_type_q;
    assign RasHitBank  = ras_hit_bank_q;
    assign RasUsed     = ras_used_q;
    assign RasPtr      = ras_ptr_q;
    assign RasCnt      = ras_cnt_q;

endmodule

// File: tb/tb_ras_predictor.sv
// -----------------------------------------------------------------------------
// tb_ras_predictor
//
// Self-checking bench for ras_predictor. A reference model of the return
// address stack computes the expected registered output for each driven
// cycle and pushes it to a scoreboard queue; each test task pops the entry
// once the DUT has produced that cycle's output and compares it.
// -----------------------------------------------------------------------------
module tb_ras_predictor;

    localparam logic [2:0] T_CALL = 3'd2;
    localparam logic [2:0] T_RET  = 3'd3;
    localparam logic [2:0] T_JMP  = 3'd1;

    typedef struct packed {
        logic        able;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [1:0]  bank;
        logic        used;
        logic [3:0]  ptr;
        logic [4:0]  cnt;
    } exp_t;

    logic        Clk;
    logic        Rest;
    logic        BtbAble;
    logic [31:0] BtbPc;
    logic [2:0]  BtbType;
    logic [1:0]  BtbHitBank;
    logic [31:0] CallRetAddr;
    logic        FlushAble;
    logic [3:0]  FlushPtr;
    logic [4:0]  FlushCnt;
    logic [31:0] FlushTopData;
    logic        RasAble;
    logic [31:0] RasNextPc;
    logic [2:0]  RasNextType;
    logic [1:0]  RasHitBank;
    logic        RasUsed;
    logic [3:0]  RasPtr;
    logic [4:0]  RasCnt;

    int checks   = 0;
    int failures = 0;

    exp_t        sb[$];
    logic [31:0] m_mem [16];
    logic [3:0]  m_ptr;
    logic [4:0]  m_cnt;

    ras_predictor dut (
        .Clk          (Clk),
        .Rest         (Rest),
        .BtbAble      (BtbAble),
        .BtbPc        (BtbPc),
        .BtbType      (BtbType),
        .BtbHitBank   (BtbHitBank),
        .CallRetAddr  (CallRetAddr),
        .FlushAble    (FlushAble),
        .FlushPtr     (FlushPtr),
        .FlushCnt     (FlushCnt),
        .FlushTopData (FlushTopData),
        .RasAble      (RasAble),
        .RasNextPc    (RasNextPc),
        .RasNextType  (RasNextType),
        .RasHitBank   (RasHitBank),
        .RasUsed      (RasUsed),
        .RasPtr       (RasPtr),
        .RasCnt       (RasCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t observe();
        exp_t o;
        o.able = RasAble;
        o.pc   = RasNextPc;
        o.typ  = RasNextType;
        o.bank = RasHitBank;
        o.used = RasUsed;
        o.ptr  = RasPtr;
        o.cnt  = RasCnt;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
        m_ptr = 4'd0;
        m_cnt = 5'd0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, predict its output, advance past the edge.
    task automatic step(input logic able, input logic [31:0] pc, input logic [2:0] typ,
                        input logic [1:0] bank, input logic [31:0] ret,
                        input logic fl, input logic [3:0] fptr, input logic [4:0] fcnt,
                        input logic [31:0] ftop);
        exp_t e;
        e = '0;
        if (fl) begin
            m_ptr = fptr;
            m_cnt = fcnt;
            if (fcnt != 5'd0) m_mem[4'(fptr - 4'd1)] = ftop;
        end else if (able) begin
            e.able = 1'b1;
            e.typ  = typ;
            e.bank = bank;
            e.ptr  = m_ptr;
            e.cnt  = m_cnt;
            e.pc   = pc;
            if (typ == T_RET && m_cnt != 5'd0) begin
                m_ptr  = m_ptr - 4'd1;
                e.pc   = m_mem[m_ptr];
                e.used = 1'b1;
                m_cnt  = m_cnt - 5'd1;
            end else if (typ == T_CALL) begin
                m_mem[m_ptr] = ret;
                m_ptr = m_ptr + 4'd1;
                if (m_cnt < 5'd16) m_cnt = m_cnt + 5'd1;
            end
        end
        sb.push_back(e);
        BtbAble      = able;
        BtbPc        = pc;
        BtbType      = typ;
        BtbHitBank   = bank;
        CallRetAddr  = ret;
        FlushAble    = fl;
        FlushPtr     = fptr;
        FlushCnt     = fcnt;
        FlushTopData = ftop;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        BtbAble = 1'b0; BtbPc = 32'h0; BtbType = 3'd0; BtbHitBank = 2'd0;
        CallRetAddr = 32'h0; FlushAble = 1'b0; FlushPtr = 4'd0; FlushCnt = 5'd0;
        FlushTopData = 32'h0;
    endtask

    task automatic test_reset();
        exp_t o;
        idle_inputs();
        Rest = 1'b0;
        model_reset();
        #12;
        o = observe();
        checks++;
        if (o !== exp_t'(0)) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", o, exp_t'(0));
        end
        @(negedge Clk);
        Rest = 1'b1;
    endtask

    task automatic test_call_ret();
        exp_t e, o;
        // call, return, idle, plain jump pass-through, return on empty
        step(1'b1, 32'h1C00_0800, T_CALL, 2'b01, 32'h1C00_0104, 1'b0, 4'd0, 5'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (sb.size() == 0) begin
                failures++; checks++;
                $display("FAIL call_ret_sb_empty got=0 want=1");
            end else begin
                e = sb.pop_front();
                o = observe();
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL call_ret[%0d] got=%h want=%h", i, o, e);
                end
            end
            case (i)
                0: step(1'b1, 32'h0000_0000, T_RET, 2'b10, 32'h0, 1'b0, 4'd0, 5'd0, 32'h0);
                1: step(1'b0, 32'hDEAD_BEEF, T_CALL, 2'b01, 32'h5555_0000, 1'b0, 4'd0, 5'd0, 32'h0);
                2: step(1'b1, 32'h1C00_2000, T_JMP, 2'b10, 32'h7777_0000, 1'b0, 4'd0, 5'd0, 32'h0);
                3: step(1'b1, 32'h1C00_0040, T_RET, 2'b00, 32'h0, 1'b0, 4'd0, 5'd0, 32'h0);
                default: ;
            endcase
        end
    endtask

    task automatic test_overflow();
        exp_t e, o;
        for (int k = 0; k < 34; k++) begin
            if (k < 17)
                step(1'b1, 32'h2000_0000 + 32'(k), T_CALL, 2'b01, 32'h100 + 32'(4 * k),
                     1'b0, 4'd0, 5'd0, 32'h0);
            else
                step(1'b1, 32'h3000_0000 + 32'(k), T_RET, 2'b10, 32'h0,
                     1'b0, 4'd0, 5'd0, 32'h0);
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL overflow[%0d] got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_flush();
        exp_t e, o;
        // flush wins over a same-cycle call, then the restored top is returned
        step(1'b1, 32'h1C00_0900, T_CALL, 2'b01, 32'h1234_5678, 1'b1, 4'd3, 5'd3, 32'hABCD_0000);
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e || RasAble !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop got=%h want=%h", o, e);
        end
        step(1'b1, 32'h1C00_0A00, T_RET, 2'b10, 32'h0, 1'b0, 4'd0, 5'd0, 32'h0);
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e || RasNextPc !== 32'hABCD_0000 || RasPtr !== 4'd3) begin
            failures++;
            $display("FAIL flush_ret got=%h want=%h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0, 1, 3: step(1'b1, 32'h4000_0000 + 32'(k), T_CALL, 2'b01,
                              32'hA000_0000 + 32'(k << 4), 1'b0, 4'd0, 5'd0, 32'h0);
                5:       step(1'b1, 32'h4000_0000, T_CALL, 2'b01, 32'h0, 1'b1, 4'd7, 5'd0,
                              32'hFFFF_FFFF);
                default: step(1'b1, 32'h4100_0000 + 32'(k), T_RET, 2'b10, 32'h0,
                              1'b0, 4'd0, 5'd0, 32'h0);
            endcase
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        step(1'b1, 32'h1C00_0800, T_CALL, 2'b01, 32'h1C00_0104, 1'b0, 4'd0, 5'd0, 32'h0);
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL mid_before got=%h want=%h", o, e);
        end
        #3;
        Rest = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== exp_t'(0)) begin
            failures++;
            $display("FAIL mid_async_clear got=%h want=%h", o, exp_t'(0));
        end
        model_reset();
        idle_inputs();
        @(negedge Clk);
        Rest = 1'b1;
        step(1'b1, 32'h1C00_0040, T_RET, 2'b10, 32'h0, 1'b0, 4'd0, 5'd0, 32'h0);
        e = sb.pop_front();
        o = observe();
        checks++;
        if (o !== e || RasUsed !== 1'b0) begin
            failures++;
            $display("FAIL mid_after_ret got=%h want=%h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
